// File: rtl/output_signature_compactor.sv
// Folds a wide output bundle into a MISR, latches the signature at each window
// boundary and shifts the latched value out LSB first on a single pin.
module output_signature_compactor #(
   parameter int unsigned DATA_WIDTH = 192,
   parameter int unsigned SIG_WIDTH  = 32,
   parameter logic [31:0] POLY       = 32'h04C11DB7,
   parameter logic [31:0] SEED       = 32'h0,
   parameter int unsigned WINDOW     = 1024
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic [DATA_WIDTH-1:0]      data_in,
   output logic [SIG_WIDTH-1:0]       signature,
   output logic                       sig_valid,
   output logic                       serial_out,
   output logic                       serial_frame,
   output logic [$clog2(WINDOW)-1:0]  window_count
);

   localparam int unsigned CW     = $clog2(WINDOW);
   localparam int unsigned BW     = $clog2(SIG_WIDTH + 1);
   localparam int unsigned NCHUNK = (DATA_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
   localparam logic [SIG_WIDTH-1:0] POLY_W = SIG_WIDTH'(POLY);
   localparam logic [SIG_WIDTH-1:0] SEED_W = SIG_WIDTH'(SEED);

   // The serial shift must finish before the next window can latch.
   if (WINDOW < SIG_WIDTH + 1) begin : g_window_too_short
      $error("output_signature_compactor: WINDOW must be >= SIG_WIDTH+1");
   end

   typedef enum logic {IDLE, SHIFT} state_t;

   logic [SIG_WIDTH-1:0]        misr;
   logic [SIG_WIDTH-1:0]        misr_nxt;
   logic [SIG_WIDTH-1:0]        fold;
   logic [NCHUNK*SIG_WIDTH-1:0] padded;
   logic                        win_end;

   state_t                      state, state_nxt;
   logic [SIG_WIDTH-1:0]        shifter, shifter_nxt;
   logic [BW-1:0]               bitcnt, bitcnt_nxt;

   always_comb begin
      padded = '0;
      padded[DATA_WIDTH-1:0] = data_in;
      fold = '0;
      for (int unsigned k = 0; k < NCHUNK; k++) begin
         fold = fold ^ padded[k*SIG_WIDTH +: SIG_WIDTH];
      end
      misr_nxt = (misr << 1) ^ (misr[SIG_WIDTH-1] ? POLY_W : '0) ^ fold;
   end

   assign win_end = enable && (window_count == CW'(WINDOW - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         misr         <= SEED_W;
         window_count <= '0;
         signature    <= '0;
         sig_valid    <= 1'b0;
      end else begin
         sig_valid <= win_end;
         if (win_end) begin
            signature    <= misr_nxt;
            misr         <= SEED_W;
            window_count <= '0;
         end else if (enable) begin
            misr         <= misr_nxt;
            window_count <= window_count + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         shifter <= '0;
         bitcnt  <= '0;
      end else begin
         state   <= state_nxt;
         shifter <= shifter_nxt;
         bitcnt  <= bitcnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      shifter_nxt  = shifter;
      bitcnt_nxt   = bitcnt;
      serial_out   = 1'b0;
      serial_frame = 1'b0;
      case (state)
         IDLE: begin
            if (win_end) begin
               state_nxt   = SHIFT;
               shifter_nxt = misr_nxt;
               bitcnt_nxt  = '0;
            end
         end
         SHIFT: begin
            serial_out   = shifter[0];
            serial_frame = 1'b1;
            if (win_end) begin
               shifter_nxt = misr_nxt;
               bitcnt_nxt  = '0;
            end else if (bitcnt == BW'(SIG_WIDTH - 1)) begin
               state_nxt   = IDLE;
               shifter_nxt = '0;
               bitcnt_nxt  = '0;
            end else begin
               shifter_nxt = shifter >> 1;
               bitcnt_nxt  = bitcnt + BW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_output_signature_compactor.sv
// Directed checks of the signature compactor: window signatures, serial
// readout, fold cancellation, enable gating and mid-operation reset.
module tb_output_signature_compactor;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en_a = 1'b0, en_b = 1'b0;
   logic [7:0]  d_a = '0;
   logic [11:0] d_b = '0;
   logic [7:0]  sig_a, sig_b;
   logic        sv_a, sv_b, so_a, so_b, fr_a, fr_b;
   logic [3:0]  wc_a, wc_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   output_signature_compactor #(
      .DATA_WIDTH(8), .SIG_WIDTH(8), .POLY(32'h1D), .SEED(32'h0), .WINDOW(9)
   ) dut_a (
      .clk(clk), .reset(reset), .enable(en_a), .data_in(d_a),
      .signature(sig_a), .sig_valid(sv_a), .serial_out(so_a),
      .serial_frame(fr_a), .window_count(wc_a)
   );

   output_signature_compactor #(
      .DATA_WIDTH(12), .SIG_WIDTH(8), .POLY(32'h1D), .SEED(32'h0), .WINDOW(9)
   ) dut_b (
      .clk(clk), .reset(reset), .enable(en_b), .data_in(d_b),
      .signature(sig_b), .sig_valid(sv_b), .serial_out(so_b),
      .serial_frame(fr_b), .window_count(wc_b)
   );

   typedef struct {
      logic [7:0] first;
      logic [7:0] last;
      logic [7:0] exp_sig;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero_a(input string tag);
      check({tag, " signature"}, 32'(sig_a), 32'h0);
      check({tag, " sig_valid"}, 32'(sv_a), 32'h0);
      check({tag, " window_count"}, 32'(wc_a), 32'h0);
      check({tag, " serial_frame"}, 32'(fr_a), 32'h0);
      check({tag, " serial_out"}, 32'(so_a), 32'h0);
   endtask

   // One full window on DUT A: 'first' in cycle 1, 'last' in cycle 9, zeros between.
   task automatic run_window_a(input logic [7:0] first, input logic [7:0] last,
                               input logic [7:0] exp, input string tag);
      for (int c = 0; c < 9; c++) begin
         en_a = 1'b1;
         d_a  = (c == 0) ? first : ((c == 8) ? last : 8'h00);
         tick();
         if (c < 8) begin
            check({tag, " wc"}, 32'(wc_a), 32'(c + 1));
            check({tag, " sv_early"}, 32'(sv_a), 32'h0);
         end
      end
      en_a = 1'b0;
      d_a  = '0;
      check({tag, " sv"}, 32'(sv_a), 32'h1);
      check({tag, " sig"}, 32'(sig_a), 32'(exp));
      check({tag, " wc_wrap"}, 32'(wc_a), 32'h0);
      for (int b = 0; b < 8; b++) begin
         check({tag, " frame"}, 32'(fr_a), 32'h1);
         check({tag, " serial"}, 32'(so_a), 32'(exp[b]));
         if (b > 0) check({tag, " sv_pulse"}, 32'(sv_a), 32'h0);
         tick();
      end
      check({tag, " frame_end"}, 32'(fr_a), 32'h0);
      check({tag, " serial_end"}, 32'(so_a), 32'h0);
   endtask

   task automatic run_window_b(input logic [11:0] first, input logic [7:0] exp,
                               input string tag);
      for (int c = 0; c < 9; c++) begin
         en_b = 1'b1;
         d_b  = (c == 0) ? first : 12'h000;
         tick();
      end
      en_b = 1'b0;
      d_b  = '0;
      check({tag, " sv"}, 32'(sv_b), 32'h1);
      check({tag, " sig"}, 32'(sig_b), 32'(exp));
      tick();
   endtask

   initial begin
      // Signature of a single cycle-1 bit i is x^(8+i) mod x^8+x^4+x^3+x^2+1.
      vecs[0] = '{8'h00, 8'h00, 8'h00};
      vecs[1] = '{8'h01, 8'h00, 8'h1D};
      vecs[2] = '{8'h80, 8'h00, 8'h26};
      vecs[3] = '{8'h03, 8'h00, 8'h27};
      vecs[4] = '{8'h00, 8'hA5, 8'hA5};
      vecs[5] = '{8'h01, 8'h01, 8'h1C};
      vecs[6] = '{8'hFF, 8'h00, 8'hC4};

      reset = 1'b0;
      tick();
      tick();
      check_zero_a("reset");
      check("reset sig_b", 32'(sig_b), 32'h0);
      reset = 1'b1;

      for (int i = 0; i < 7; i++) begin
         run_window_a(vecs[i].first, vecs[i].last, vecs[i].exp_sig, $sformatf("vec%0d", i));
         tick();
      end

      // Enable gating: 5 frozen cycles after window cycle 4.
      for (int c = 0; c < 4; c++) begin
         en_a = 1'b1;
         d_a  = (c == 0) ? 8'h01 : 8'h00;
         tick();
      end
      for (int c = 0; c < 5; c++) begin
         en_a = 1'b0;
         d_a  = 8'hFF;
         tick();
         check("gate wc_hold", 32'(wc_a), 32'h4);
         check("gate sv", 32'(sv_a), 32'h0);
      end
      for (int c = 0; c < 5; c++) begin
         en_a = 1'b1;
         d_a  = 8'h00;
         tick();
         if (c < 4) check("gate sv_early", 32'(sv_a), 32'h0);
      end
      en_a = 1'b0;
      check("gate sv", 32'(sv_a), 32'h1);
      check("gate sig", 32'(sig_a), 32'h1D);
      repeat (10) tick();

      // Reset at window cycle 5.
      for (int c = 0; c < 5; c++) begin
         en_a = 1'b1;
         d_a  = (c == 0) ? 8'h01 : 8'h00;
         tick();
      end
      reset = 1'b0;
      d_a   = 8'h55;
      tick();
      check_zero_a("rst_mid_window");
      reset = 1'b1;
      en_a  = 1'b0;
      tick();
      check("rst_mid_window no_sv", 32'(sv_a), 32'h0);
      run_window_a(8'h01, 8'h00, 8'h1D, "after_rst1");
      tick();

      // Reset at serial bit 3.
      for (int c = 0; c < 9; c++) begin
         en_a = 1'b1;
         d_a  = (c == 0) ? 8'h80 : 8'h00;
         tick();
      end
      en_a = 1'b0;
      check("pre_rst sig", 32'(sig_a), 32'h26);
      tick();
      tick();
      tick();
      check("pre_rst frame", 32'(fr_a), 32'h1);
      reset = 1'b0;
      tick();
      check_zero_a("rst_mid_serial");
      reset = 1'b1;
      tick();
      check("rst_mid_serial frame_after", 32'(fr_a), 32'h0);
      run_window_a(8'h01, 8'h00, 8'h1D, "after_rst2");

      // Fold cancellation on the 12-bit instance.
      run_window_b(12'hF0F, 8'h00, "fold_cancel");
      run_window_b(12'h001, 8'h1D, "fold_low");
      run_window_b(12'h100, 8'h1D, "fold_high");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
